// File: rtl/psx_pkg.sv
// Shared types and constants for the PSX controller poll master.
package psx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SHIFT_LO,
        SHIFT_HI,
        BYTE_GAP,
        DESELECT,
        NEXT_PORT
    } state_t;

    localparam logic [7:0] CMD_POLL = 8'h01;
    localparam logic [7:0] CMD_READ = 8'h42;
    localparam logic [7:0] CMD_FILL = 8'h00;
    localparam logic       IDLE_LVL = 1'b1;

    function automatic logic [7:0] cmd_byte(input int idx);
        if (idx == 0)
            return CMD_POLL;
        else if (idx == 1)
            return CMD_READ;
        else
            return CMD_FILL;
    endfunction

endpackage

// File: rtl/psx_byte_shifter.sv
// One-byte LSB-first serialiser: psx_clk divider, LO/HI phase,
// command/response shift registers and bit counter.
module psx_byte_shifter
    import psx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       data,
    output logic       tick,
    output logic       last,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       psx_clk,
    output logic       cmd
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic          active;
    logic          hi;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;

    assign tick = active && (div_cnt == DW'(CLK_DIV - 1));
    assign last = (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            hi      <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_byte <= '0;
            done    <= 1'b0;
            psx_clk <= IDLE_LVL;
            cmd     <= IDLE_LVL;
        end else begin
            done <= 1'b0;
            if (load) begin
                active  <= 1'b1;
                hi      <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
                psx_clk <= 1'b0;
                cmd     <= tx_byte[0];
                tx_sr   <= {1'b1, tx_byte[7:1]};
            end else if (active) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    if (!hi) begin
                        // rising edge: controller data is sampled here only
                        hi      <= 1'b1;
                        psx_clk <= 1'b1;
                        rx_sr   <= {data, rx_sr[7:1]};
                    end else if (last) begin
                        active  <= 1'b0;
                        hi      <= 1'b0;
                        done    <= 1'b1;
                        rx_byte <= rx_sr;
                        cmd     <= IDLE_LVL;
                    end else begin
                        hi      <= 1'b0;
                        psx_clk <= 1'b0;
                        cmd     <= tx_sr[0];
                        tx_sr   <= {1'b1, tx_sr[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/psx_poll_master.sv
// Polls every PSX controller port once per start request.
// Define PSX_ACK_TIMEOUT_EN to pace bytes on ack with a timeout.
module psx_poll_master
    import psx_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int BYTES       = 5,
    parameter int CLK_DIV     = 4,
    parameter int ACK_TIMEOUT = 32,
    parameter int ACK_GAP     = 8,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    input  logic                 data,
    input  logic                 ack,
    output logic                 psx_clk,
    output logic                 cmd,
    output logic [NUM_PORTS-1:0] att,
    output logic                 rx_valid,
    output logic [7:0]           rx_byte,
    output logic [PW-1:0]        rx_port,
    output logic [IW-1:0]        rx_index,
    output logic [NUM_PORTS-1:0] port_err
);

    localparam int WMAX    = (ACK_TIMEOUT > ACK_GAP) ? ACK_TIMEOUT : ACK_GAP;
    localparam int CNT_MAX = WMAX + 2 * CLK_DIV;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t               state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [PW-1:0]        port, port_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic [NUM_PORTS-1:0] err, err_nx;
    logic                 sh_load, sh_tick, sh_last;
    logic [7:0]           sh_tx;

`ifdef PSX_ACK_TIMEOUT_EN
    logic acked, acked_nx;
`else
    logic unused_ack;
    assign unused_ack = ack;
`endif

    psx_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (sh_load),
        .tx_byte (sh_tx),
        .data    (data),
        .tick    (sh_tick),
        .last    (sh_last),
        .done    (rx_valid),
        .rx_byte (rx_byte),
        .psx_clk (psx_clk),
        .cmd     (cmd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            port  <= '0;
            idx   <= '0;
            err   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            port  <= port_nx;
            idx   <= idx_nx;
            err   <= err_nx;
        end
    end

`ifdef PSX_ACK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst)
            acked <= 1'b0;
        else
            acked <= acked_nx;
    end
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        port_nx  = port;
        idx_nx   = idx;
        err_nx   = err;
        sh_load  = 1'b0;
        sh_tx    = CMD_FILL;
`ifdef PSX_ACK_TIMEOUT_EN
        acked_nx = acked;
`endif
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (start) begin
                    state_nx = SELECT;
                    port_nx  = '0;
                    idx_nx   = '0;
                    err_nx   = '0;
                end
            end
            SELECT: begin
                if (cnt == CW'(2 * CLK_DIV - 1)) begin
                    sh_load  = 1'b1;
                    sh_tx    = cmd_byte(0);
                    state_nx = SHIFT_LO;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            SHIFT_LO: begin
                if (sh_tick)
                    state_nx = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (sh_tick) begin
                    if (!sh_last) begin
                        state_nx = SHIFT_LO;
                    end else if (idx == IW'(BYTES - 1)) begin
                        state_nx = DESELECT;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = BYTE_GAP;
`ifdef PSX_ACK_TIMEOUT_EN
                        // the final HI phase already counts toward the timeout
                        cnt_nx   = CW'(CLK_DIV);
                        acked_nx = 1'b0;
`else
                        cnt_nx   = '0;
`endif
                    end
                end
            end
            BYTE_GAP: begin
`ifdef PSX_ACK_TIMEOUT_EN
                if (acked) begin
                    if (cnt == CW'(CLK_DIV - 1)) begin
                        sh_load  = 1'b1;
                        sh_tx    = cmd_byte(int'(idx) + 1);
                        idx_nx   = idx + 1'b1;
                        state_nx = SHIFT_LO;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else if (!ack) begin
                    acked_nx = 1'b1;
                    cnt_nx   = '0;
                end else if (cnt >= CW'(ACK_TIMEOUT - 1)) begin
                    err_nx[port] = 1'b1;
                    state_nx     = DESELECT;
                    cnt_nx       = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
`else
                if (cnt == CW'(ACK_GAP - 1)) begin
                    sh_load  = 1'b1;
                    sh_tx    = cmd_byte(int'(idx) + 1);
                    idx_nx   = idx + 1'b1;
                    state_nx = SHIFT_LO;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
`endif
            end
            DESELECT: begin
                if (cnt == CW'(2 * CLK_DIV - 1))
                    state_nx = NEXT_PORT;
                else
                    cnt_nx = cnt + 1'b1;
            end
            NEXT_PORT: begin
                cnt_nx = '0;
                if (port == PW'(NUM_PORTS - 1)) begin
                    state_nx = IDLE;
                end else begin
                    port_nx  = port + 1'b1;
                    idx_nx   = '0;
                    state_nx = SELECT;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        att = '1;
        if (state inside {SELECT, SHIFT_LO, SHIFT_HI, BYTE_GAP})
            att[port] = 1'b0;
    end

    assign busy     = (state != IDLE);
    assign rx_port  = port;
    assign rx_index = idx;
    assign port_err = err;

endmodule

// File: tb/tb_psx_poll_master.sv
// Scoreboard bench for psx_poll_master with a port-0 controller model.
module tb_psx_poll_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       data = 1'b1;
    logic       ack = 1'b1;
    logic       busy, psx_clk, cmd, rx_valid;
    logic [1:0] att, port_err;
    logic [7:0] rx_byte;
    logic [0:0] rx_port;
    logic [2:0] rx_index;

    psx_poll_master dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .data     (data),
        .ack      (ack),
        .psx_clk  (psx_clk),
        .cmd      (cmd),
        .att      (att),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_port  (rx_port),
        .rx_index (rx_index),
        .port_err (port_err)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int nrx  = 0;

    logic [15:0] exp_rx[$];
    logic [7:0]  exp_cmd[$];
    logic [7:0]  resp[5] = '{8'hFF, 8'h41, 8'h5A, 8'h12, 8'h34};
    logic [7:0]  cmds[5] = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // rx scoreboard monitor
    always @(negedge clk) begin
        if (!rst && rx_valid) begin
            nrx++;
            if (exp_rx.size() == 0) begin
                chk("rx_unexpected", {16'd0, 4'(rx_port), 4'(rx_index), rx_byte}, 32'hFFFF);
            end else begin
                chk("rx_beat", {16'd0, 4'(rx_port), 4'(rx_index), rx_byte},
                    {16'd0, exp_rx.pop_front()});
            end
        end
    end

    // controller model and cmd / timing monitor
    int          cbit = 0, dbit = 0, dbyte = 0;
    int          ack_dly = 0, ack_hold = 0;
    bit          seen_byte = 0;
    logic [7:0]  cbyte;
    time         t_rise = 0, t_fall = 0;

    always @(negedge clk) begin
        if (&att) begin
            cbit      = 0;
            dbit      = 0;
            dbyte     = 0;
            seen_byte = 0;
            data      = 1'b1;
        end
        if (rst) begin
            ack_dly  = 0;
            ack_hold = 0;
        end
        if (ack_hold > 0) begin
            ack = 1'b0;
            ack_hold--;
        end else begin
            ack = 1'b1;
        end
        if (ack_dly > 0) begin
            ack_dly--;
            if (ack_dly == 0)
                ack_hold = 2;
        end
    end

    always @(negedge psx_clk) begin
        if (!rst) begin
            t_fall = $time;
            if (cbit != 0)
                chk("hi_phase", 32'($time - t_rise), 32'd40);
`ifndef PSX_ACK_TIMEOUT_EN
            else if (seen_byte)
                chk("byte_gap", 32'($time - t_rise), 32'd120);
`endif
            if (!att[0] && dbyte < 5) begin
                data = resp[dbyte][dbit];
                dbit++;
                if (dbit == 8) begin
                    dbit = 0;
                    dbyte++;
                end
            end
        end
    end

    always @(posedge psx_clk) begin
        if (!rst) begin
            t_rise = $time;
            chk("lo_phase", 32'($time - t_fall), 32'd40);
            cbyte[cbit] = cmd;
            cbit++;
            if (cbit == 8) begin
                cbit      = 0;
                seen_byte = 1;
                if (!att[0])
                    ack_dly = 6;
                if (exp_cmd.size() == 0)
                    chk("cmd_unexpected", {24'd0, cbyte}, 32'hFFFF);
                else
                    chk("cmd_byte", {24'd0, cbyte}, {24'd0, exp_cmd.pop_front()});
            end
        end
    end

    int         n_p1;
    logic [1:0] exp_err;

    task automatic push_frame();
        for (int i = 0; i < 5; i++) begin
            exp_rx.push_back({4'd0, 4'(i), resp[i]});
            exp_cmd.push_back(cmds[i]);
        end
        for (int i = 0; i < n_p1; i++) begin
            exp_rx.push_back({4'd1, 4'(i), 8'hFF});
            exp_cmd.push_back(cmds[i]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && busy; i++)
            @(negedge clk);
        chk("frame_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic frame_end_checks(input string tag);
        chk({tag, "_rx_count"}, nrx, 5 + n_p1);
        chk({tag, "_port_err"}, {30'd0, port_err}, {30'd0, exp_err});
        chk({tag, "_att"}, {30'd0, att}, 32'h3);
        chk({tag, "_queue"}, exp_rx.size() + exp_cmd.size(), 0);
    endtask

    initial begin
`ifdef PSX_ACK_TIMEOUT_EN
        n_p1    = 1;
        exp_err = 2'b10;
`else
        n_p1    = 5;
        exp_err = 2'b00;
`endif
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_att", {30'd0, att}, 32'h3);
        chk("rst_psx_clk", {31'd0, psx_clk}, 32'd1);
        chk("rst_cmd", {31'd0, cmd}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rx", {16'd0, 7'd0, rx_valid, rx_byte}, 32'd0);
        chk("rst_port_idx_err", {26'd0, rx_port, rx_index, port_err}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("rst_beats_start", {31'd0, busy}, 32'd0);

        // frame 1, with a start pulse while busy
        nrx = 0;
        push_frame();
        pulse_start();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        repeat (100) @(negedge clk);
        pulse_start();
        wait_idle();
        frame_end_checks("f1");

        // frame 2 from IDLE
        repeat (5) @(negedge clk);
        nrx = 0;
        push_frame();
        pulse_start();
        wait_idle();
        frame_end_checks("f2");

        // frame 3 aborted by reset during byte 2 of port 0
        repeat (5) @(negedge clk);
        nrx = 0;
        for (int i = 0; i < 2; i++) begin
            exp_rx.push_back({4'd0, 4'(i), resp[i]});
            exp_cmd.push_back(cmds[i]);
        end
        pulse_start();
        for (int i = 0; i < 2000 && nrx < 2; i++)
            @(negedge clk);
        chk("abort_wait", nrx, 2);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_att", {30'd0, att}, 32'h3);
        chk("abort_psx_clk", {31'd0, psx_clk}, 32'd1);
        chk("abort_cmd", {31'd0, cmd}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        chk("abort_rx_count", nrx, 2);
        chk("abort_queue", exp_rx.size() + exp_cmd.size(), 0);

        // frame 4 after recovery
        nrx = 0;
        push_frame();
        pulse_start();
        wait_idle();
        frame_end_checks("f4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/psx_poll_master.md
PSX_POLL_MASTER -- requirements
Module: psx_poll_master

Interface
REQ-001 SHALL declare parameter NUM_PORTS, default 2: number of controller ports polled, each with its own att line.
REQ-002 SHALL declare parameter BYTES, default 5: bytes exchanged per port per frame (minimum 3).
REQ-003 SHALL declare parameter CLK_DIV, default 4: clk cycles per psx_clk half-period.
REQ-004 SHALL declare parameter ACK_TIMEOUT, default 32: clk cycles allowed between a byte's last rising edge and ack low.
REQ-005 SHALL declare parameter ACK_GAP, default 8: fixed inter-byte gap in clk cycles when ack is not monitored.
REQ-006 SHALL have ports, clock and reset first: clk in 1, system clock; rst in 1, reset, synchronous active-high.
REQ-007 SHALL have ports: start in 1 (poll all ports once); busy out 1 (frame in progress).
REQ-008 SHALL have ports: data in 1 (controller to host, idle high); ack in 1 (active-low byte acknowledge).
REQ-009 SHALL have ports: psx_clk out 1 (idle high); cmd out 1 (host to controller, idle high); att out NUM_PORTS (active-low port select).
REQ-010 SHALL have ports: rx_valid out 1 (one-cycle strobe); rx_byte out 8; rx_port out clog2(NUM_PORTS); rx_index out clog2(BYTES); port_err out NUM_PORTS (sticky per frame: port timed out).

Function
REQ-011 SHALL use states IDLE, SELECT, SHIFT_LO, SHIFT_HI, BYTE_GAP, DESELECT, NEXT_PORT.
REQ-012 SHALL accept start only in IDLE; busy goes high the cycle after start and stays high until return to IDLE; start while busy is ignored.
REQ-013 SHALL clear port_err when start is accepted, then poll ports 0..NUM_PORTS-1 in ascending order.
REQ-014 SELECT: drive att[p] low, all other att high, and hold it for 2*CLK_DIV cycles before the first bit.
REQ-015 SHALL transmit command bytes 0x01, 0x42, then 0x00 for each remaining byte, LSB first.
REQ-016 SHIFT_LO: drive psx_clk low and update cmd with the next bit on entry; hold for CLK_DIV cycles.
REQ-017 SHIFT_HI: drive psx_clk high and sample data on entry; hold for CLK_DIV cycles. Eight LO/HI pairs make one byte.
REQ-018 After bit 7 is sampled, SHALL pulse rx_valid for exactly one cycle with rx_byte, rx_port = p, rx_index = byte number.
REQ-019 cmd SHALL return high in BYTE_GAP and DESELECT.
REQ-020 After the last byte (index BYTES-1), SHALL enter DESELECT without waiting for ack, raise att[p], and hold it for 2*CLK_DIV cycles.
REQ-021 NEXT_PORT: increment p; after port NUM_PORTS-1, go to IDLE and drop busy in that same cycle.
REQ-022 A pulse on ack outside BYTE_GAP SHALL be ignored; data SHALL be sampled only in SHIFT_HI entry cycles.

Reset
REQ-023 While rst is high: state IDLE, att all 1, psx_clk 1, cmd 1, busy 0, rx_valid 0, rx_byte 0, rx_port 0, rx_index 0, port_err 0.
REQ-024 rst asserted mid-frame SHALL abort within the same clk edge; no further rx_valid from the aborted frame.
REQ-025 Reset SHALL take priority over a simultaneous start.

Configuration
REQ-026 With PSX_ACK_TIMEOUT_EN defined, BYTE_GAP SHALL wait for ack low. On ack low, the next byte starts after CLK_DIV cycles.
REQ-027 With PSX_ACK_TIMEOUT_EN defined, if ack is not seen within ACK_TIMEOUT cycles, SHALL set port_err[p], skip the remaining bytes, and go to DESELECT.
REQ-028 Without PSX_ACK_TIMEOUT_EN, ack SHALL be ignored, BYTE_GAP SHALL last exactly ACK_GAP cycles, and port_err SHALL stay 0.

Structure
REQ-029 A shared package psx_pkg SHALL hold the state enum, the command constants (0x01 poll, 0x42 read) and the idle-level constant.
REQ-030 The bit serialiser (divider, LO/HI phase, shift registers, bit counter) SHALL be sub-module psx_byte_shifter, instantiated once.

Verification
REQ-031 Settings NUM_PORTS=2, BYTES=5, CLK_DIV=4. Controller on port 0 returns FF 41 5A 12 34 with ack after each byte -> 5 rx_valid pulses with those bytes, rx_port 0, rx_index 0..4; port_err 00.
REQ-032 Check cmd bits on psx_clk rising edges -> LSB-first 0x01, 0x42, 0x00, 0x00, 0x00; each psx_clk phase is 4 clk cycles.
REQ-033 PSX_ACK_TIMEOUT_EN defined, port 1 empty (data high, no ack) -> one rx_valid for port 1 with byte FF, port_err = 10, att[1] high afterwards, busy drops.
REQ-034 Macro undefined, port 1 empty -> 5 rx_valid pulses of FF for port 1, port_err = 00, 8-cycle gaps between bytes.
REQ-035 rst pulsed during byte 2 of port 0 -> the next cycle shows att 11, psx_clk 1, cmd 1, busy 0, and no further rx_valid.
REQ-036 start reasserted while busy -> ignored: exactly 10 rx_valid pulses per frame, then start in IDLE begins a new frame.
